rf_writeback: RTL and testbench

RF_WRITEBACK -- requirements
Module: rf_writeback

---
 rtl/rf_writeback.sv | 139 +++++++++++++
 tb/tb_rf_writeback.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/rf_writeback.sv
// Generic synchronous FIFO holding deferred B-path writebacks.
// Latency: a push is visible at dout one edge later; a pop takes effect at the edge.
// Backpressure: a push is dropped when full, even if a pop happens in the same cycle.
module rf_writeback_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  // Fullness is judged on the pre-edge count, so a same-cycle pop never frees a slot.
  assign do_push = push && (count != FULL);
  assign do_pop  = pop && (count != '0);
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push && !rst) mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// Register-file writeback arbiter: ALU path has priority, B path drains a FIFO, scoreboard tracks pending B writes.
// Latency: A request written one edge after it is presented; B request at least two edges (enqueue, then write).
// Backpressure: none on A; bReady drops while the B queue is full or in reset.
module rf_writeback #(
  parameter int n     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     aValid,
  input  logic [4:0]               aAddr,
  input  logic [n-1:0]             aData,
  input  logic                     bValid,
  output logic                     bReady,
  input  logic [4:0]               bAddr,
  input  logic [n-1:0]             bData,
  input  logic                     issueValid,
  input  logic [4:0]               issueAddr,
  input  logic [4:0]               chkAddr1,
  input  logic [4:0]               chkAddr2,
  output logic                     busy1,
  output logic                     busy2,
  output logic                     regWrite,
  output logic [4:0]               writeAddr,
  output logic [n-1:0]             writeData,
  output logic [$clog2(DEPTH):0]   fifoCount
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic         a_hit;
  logic         q_empty;
  logic         q_push;
  logic         q_pop;
  logic [n+4:0] q_head;
  logic [31:0]  pending;
  logic [31:0]  set_vec;
  logic [31:0]  clr_vec;

  // A write to x0 counts as no request, letting the queue drain that cycle.
  assign a_hit   = aValid && (aAddr != 5'd0);
  assign q_empty = (fifoCount == '0);
  assign bReady  = (fifoCount != FULL) && !rst;
  assign q_push  = bValid && bReady && (bAddr != 5'd0);
  assign q_pop   = !a_hit && !q_empty;

  rf_writeback_fifo #(
    .W     (n + 5),
    .DEPTH (DEPTH)
  ) u_bq (
    .clk   (clk),
    .rst   (rst),
    .push  (q_push),
    .pop   (q_pop),
    .din   ({bAddr, bData}),
    .dout  (q_head),
    .count (fifoCount)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      regWrite  <= 1'b0;
      writeAddr <= 5'd0;
      writeData <= '0;
    end else if (a_hit) begin
      regWrite  <= 1'b1;
      writeAddr <= aAddr;
      writeData <= aData;
    end else if (!q_empty) begin
      regWrite  <= 1'b1;
      writeAddr <= q_head[n+4:n];
      writeData <= q_head[n-1:0];
    end else begin
      regWrite  <= 1'b0;
    end
  end

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (issueValid && (issueAddr != 5'd0)) set_vec[issueAddr] = 1'b1;
    if (q_pop) clr_vec[q_head[n+4:n]] = 1'b1;
  end

  // OR-ing the set after the clear makes a same-cycle re-issue keep the bit.
  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= (pending & ~clr_vec) | set_vec;
  end

  assign busy1 = (chkAddr1 != 5'd0) && pending[chkAddr1];
  assign busy2 = (chkAddr2 != 5'd0) && pending[chkAddr2];
endmodule

// File: tb/tb_rf_writeback.sv
// Bench for rf_writeback: vector table for single-cycle behaviour, hand sequences for backpressure and reset.
module tb_rf_writeback;
  localparam int N = 32;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst, aValid, bValid, issueValid;
  logic [4:0]  aAddr, bAddr, issueAddr, chkAddr1, chkAddr2;
  logic [31:0] aData, bData;
  logic        bReady, busy1, busy2, regWrite;
  logic [4:0]  writeAddr;
  logic [31:0] writeData;
  logic [2:0]  fifoCount;

  rf_writeback #(.n(N), .DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .aValid(aValid), .aAddr(aAddr), .aData(aData),
    .bValid(bValid), .bReady(bReady), .bAddr(bAddr), .bData(bData),
    .issueValid(issueValid), .issueAddr(issueAddr),
    .chkAddr1(chkAddr1), .chkAddr2(chkAddr2), .busy1(busy1), .busy2(busy2),
    .regWrite(regWrite), .writeAddr(writeAddr), .writeData(writeData),
    .fifoCount(fifoCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r, av, bv, iv;
    logic [4:0]  aa, ba, ia, c1, c2;
    logic [31:0] ad, bd;
    logic        rw, brdy, b1, b2;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [2:0]  cnt;
  } vec_t;

  int          total = 0;
  int          bad   = 0;
  logic [36:0] exp_q[$];
  logic [36:0] sb_e;
  vec_t        tbl[$];
  vec_t        v;
  logic        s_av, s_bv;
  logic [4:0]  s_ba;
  int          exp_cnt[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
    end
  endtask

  // Every register-file write must match the next expected write, in order.
  always @(negedge clk) begin
    if (regWrite === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected_write: got addr %0d data 0x%0h, expected no write", writeAddr, writeData);
      end else begin
        sb_e = exp_q.pop_front();
        check("sb_addr", {27'd0, writeAddr}, {27'd0, sb_e[36:32]});
        check("sb_data", writeData, sb_e[31:0]);
      end
    end
  end

  function automatic vec_t mk(input logic r, input logic av, input logic [4:0] aa, input logic [31:0] ad,
                              input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                              input logic iv, input logic [4:0] ia, input logic [4:0] c1, input logic [4:0] c2,
                              input logic rw, input logic [4:0] wa, input logic [31:0] wd,
                              input logic [2:0] cnt, input logic brdy, input logic b1, input logic b2);
    vec_t t;
    t.r = r; t.av = av; t.aa = aa; t.ad = ad; t.bv = bv; t.ba = ba; t.bd = bd;
    t.iv = iv; t.ia = ia; t.c1 = c1; t.c2 = c2;
    t.rw = rw; t.wa = wa; t.wd = wd; t.cnt = cnt; t.brdy = brdy; t.b1 = b1; t.b2 = b2;
    return t;
  endfunction

  task automatic drive(input logic r, input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                       input logic iv, input logic [4:0] ia, input logic [4:0] c1, input logic [4:0] c2);
    rst = r; aValid = av; aAddr = aa; aData = ad; bValid = bv; bAddr = ba; bData = bd;
    issueValid = iv; issueAddr = ia; chkAddr1 = c1; chkAddr2 = c2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    //           r av aa ad       bv ba  bd       iv ia  c1 c2  rw wa  wd        cnt brdy b1 b2
    tbl.push_back(mk(1, 0, 0, 0,        0, 0,  0,       0, 0,  0, 0,  0, 0,  0,        0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 3, 'hFF,     1, 4,  'h44,    1, 6,  6, 4,  0, 0,  0,        0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,        0, 0,  0,       0, 0,  6, 4,  0, 0,  0,        0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 5, 'h1234,   0, 0,  0,       0, 0,  0, 0,  1, 5,  'h1234,   0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,        0, 0,  0,       0, 0,  0, 0,  0, 5,  'h1234,   0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,        0, 0,  0,       1, 7,  7, 0,  0, 5,  'h1234,   0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,        1, 7,  'hCAFE,  0, 0,  7, 0,  0, 5,  'h1234,   1, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,        0, 0,  0,       0, 0,  7, 0,  1, 7,  'hCAFE,   0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 'hDEAD,   1, 0,  'hBEEF,  1, 0,  0, 0,  0, 7,  'hCAFE,   0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,        0, 0,  0,       1, 9,  9, 0,  0, 7,  'hCAFE,   0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,        1, 9,  'h99,    0, 0,  9, 0,  0, 7,  'hCAFE,   1, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,        0, 0,  0,       1, 9,  9, 0,  1, 9,  'h99,     0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,        0, 0,  0,       0, 0,  9, 0,  0, 9,  'h99,     0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,        1, 10, 'hA0,    0, 0,  0, 9,  0, 9,  'h99,     1, 1, 0, 1));
    tbl.push_back(mk(0, 1, 0, 'h55,     0, 0,  0,       0, 0,  0, 9,  1, 10, 'hA0,     0, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0,        1, 11, 'hB1,    0, 0,  0, 0,  0, 10, 'hA0,     1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,        1, 12, 'hC2,    0, 0,  0, 0,  1, 11, 'hB1,     1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,        0, 0,  0,       0, 0,  0, 0,  1, 12, 'hC2,     0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 'h11,     1, 2,  'h22,    0, 0,  0, 0,  1, 1,  'h11,     1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,        0, 0,  0,       0, 0,  0, 0,  1, 2,  'h22,     0, 1, 0, 0));

    foreach (tbl[i]) begin
      v = tbl[i];
      drive(v.r, v.av, v.aa, v.ad, v.bv, v.ba, v.bd, v.iv, v.ia, v.c1, v.c2);
      if (v.rw) exp_q.push_back({v.wa, v.wd});
      tick();
      check($sformatf("v%0d.regWrite", i),  {31'd0, regWrite}, {31'd0, v.rw});
      check($sformatf("v%0d.writeAddr", i), {27'd0, writeAddr}, {27'd0, v.wa});
      check($sformatf("v%0d.writeData", i), writeData, v.wd);
      check($sformatf("v%0d.fifoCount", i), {29'd0, fifoCount}, {29'd0, v.cnt});
      check($sformatf("v%0d.bReady", i),    {31'd0, bReady}, {31'd0, v.brdy});
      check($sformatf("v%0d.busy1", i),     {31'd0, busy1}, {31'd0, v.b1});
      check($sformatf("v%0d.busy2", i),     {31'd0, busy2}, {31'd0, v.b2});
    end

    // Backpressure: A held for 6 cycles starves the queue; B item 24 is refused while full.
    exp_cnt = '{1, 2, 3, 4, 4, 4, 3, 3, 2, 1, 0};
    for (int k = 0; k < 11; k++) begin
      s_av = (k < 6);
      s_bv = (k < 8);
      s_ba = (k < 4) ? 5'(20 + k) : ((k < 8) ? 5'd24 : 5'd0);
      if (k < 6) exp_q.push_back({5'd3, 32'h100 + 32'(k)});
      else       exp_q.push_back({5'(20 + k - 6), 32'h2000 + 32'(20 + k - 6)});
      drive(0, s_av, 3, 32'h100 + 32'(k), s_bv, s_ba, 32'h2000 + 32'(s_ba), 0, 0, 0, 0);
      tick();
      check($sformatf("bp%0d.fifoCount", k), {29'd0, fifoCount}, 32'(exp_cnt[k]));
      check($sformatf("bp%0d.bReady", k),    {31'd0, bReady}, {31'd0, exp_cnt[k] != D});
      check($sformatf("bp%0d.regWrite", k),  {31'd0, regWrite}, 32'd1);
    end

    // Reset mid-run: three queued entries with pending bits, then reset discards them.
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back({5'd4, 32'h400 + 32'(k)});
      drive(0, 1, 4, 32'h400 + 32'(k), 1, 5'(25 + k), 32'h2500 + 32'(k), 1, 5'(25 + k), 0, 0);
      tick();
    end
    chkAddr1 = 5'd25;
    chkAddr2 = 5'd27;
    #1;
    check("pre_rst.fifoCount", {29'd0, fifoCount}, 32'd3);
    check("pre_rst.busy1", {31'd0, busy1}, 32'd1);
    check("pre_rst.busy2", {31'd0, busy2}, 32'd1);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 25, 27);
    tick();
    check("rst.fifoCount", {29'd0, fifoCount}, 32'd0);
    check("rst.regWrite",  {31'd0, regWrite}, 32'd0);
    check("rst.writeAddr", {27'd0, writeAddr}, 32'd0);
    check("rst.writeData", writeData, 32'd0);
    check("rst.bReady",    {31'd0, bReady}, 32'd0);
    check("rst.busy1",     {31'd0, busy1}, 32'd0);
    check("rst.busy2",     {31'd0, busy2}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 25, 27);
      tick();
      check($sformatf("post_rst%0d.regWrite", k),  {31'd0, regWrite}, 32'd0);
      check($sformatf("post_rst%0d.fifoCount", k), {29'd0, fifoCount}, 32'd0);
      check($sformatf("post_rst%0d.bReady", k),    {31'd0, bReady}, 32'd1);
      check($sformatf("post_rst%0d.busy1", k),     {31'd0, busy1}, 32'd0);
      check($sformatf("post_rst%0d.busy2", k),     {31'd0, busy2}, 32'd0);
    end

    @(negedge clk);
    check("sb_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
